bbox_frame_collector: RTL
=========================

// Module: bbox_frame_collector
// PURPOSE
//  Consumer of the SVM detector's bbox event interface (bbox_valid + 4 coords, done pulse per frame).
//  Collects every detection of a frame into a ping-pong box store; on frame end swaps banks and
//  replays that frame's boxes as a valid/ready stream to the overlay/readout logic.
//  The detector is never stalled: boxes arrive as single-cycle events with no backpressure.
// PARAMETERS
//  MAX_BOXES    64  boxes stored per frame (per bank); power of two, >=2
//  COORD_WIDTH  16  width of each bbox coordinate
// PORTS
//  clk              in   1               single clock; all logic on rising edge
//  reset_n          in   1               asynchronous, active-low reset
//  bbox_valid_in    in   1               1-cycle detection event
//  bbox_x_start_in  in   COORD_WIDTH     detection left edge
//  bbox_y_start_in  in   COORD_WIDTH     detection top edge
//  bbox_x_end_in    in   COORD_WIDTH     detection right edge
//  bbox_y_end_in    in   COORD_WIDTH     detection bottom edge
//  frame_done_in    in   1               1-cycle end-of-frame pulse (detector done)
//  box_valid_out    out  1               output box present
//  box_ready_in     in   1               consumer accepts box when valid&ready
//  box_out          out  4*COORD_WIDTH   {x_start,y_start,x_end,y_end}
//  box_last_out     out  1               box is the final box of its frame
//  frame_count_out  out  clog2(MAX+1)    boxes stored for frame being replayed; held until next swap
//  frame_overflow_out out 1              replayed frame lost boxes (>MAX_BOXES); held until next swap
//  frame_empty_out  out  1               1-cycle pulse: swapped frame had zero boxes
//  frame_dropped_out out 1               1-cycle pulse: frame end arrived while replay busy; frame discarded
// BEHAVIOUR
//  - Reset (async, reset_n=0): all outputs 0, write count 0, both banks free, read FSM IDLE, wr bank=0.
//  - Write side: on bbox_valid_in, if wr_count<MAX_BOXES store coords at wr_count, wr_count++;
//    else drop box, set wr_overflow. Storage content is not reset; only counts/flags are.
//  - frame_done_in: if read FSM IDLE -> swap banks next cycle: rd bank <= wr bank, latch
//    frame_count_out<=wr_count(+1 if same-cycle box accepted), frame_overflow_out<=wr_overflow;
//    clear wr_count/wr_overflow. If FSM not IDLE -> frame_dropped_out pulse, clear wr_count/overflow, no swap.
//  - Same-cycle bbox_valid_in & frame_done_in: the box belongs to the closing frame (or counts toward its overflow).
//  - Read FSM: IDLE -> (swap, count>0) FETCH; (swap, count=0) IDLE + frame_empty_out pulse.
//    FETCH: read addr rd_idx (1-cycle storage latency) -> PRESENT.
//    PRESENT: box_valid_out=1, box_out/box_last_out stable until handshake; box_last_out=(rd_idx==count-1).
//    On valid&ready: if last -> IDLE; else rd_idx++ -> FETCH. Throughput: 1 box / 2 cycles minimum.
//  - box_valid_out never drops without handshake; box_out must not change while valid&!ready.
//  - Write side continues filling the other bank during replay; banks never alias.
//  - frame_done_in with wr_count=0 and FSM IDLE: swap, frame_empty_out pulse, no stream.
//  - Latency: frame_done_in at cycle T -> frame_empty_out or box_valid_out at T+2 earliest.
//  - Reset mid-replay: stream aborts immediately, box_valid_out=0 asynchronously.
// TESTING
//  - 3 boxes (10,20,73,147),(18,20,81,147),(26,28,89,155), done; ready=1 -> 3 boxes in order,
//    last only on 3rd, frame_count_out=3, overflow=0.
//  - Frame with 0 boxes, done -> frame_empty_out single pulse at T+2, box_valid_out stays 0.
//  - MAX_BOXES+5 boxes (coords=index), done -> MAX_BOXES boxes 0..MAX-1 replayed, overflow=1, count=MAX.
//  - Replay frame A with ready held 0; send frame B (2 boxes) + done -> frame_dropped_out pulse;
//    release ready -> only A's boxes; following frame C replays correctly with overflow=0.
//  - bbox_valid_in and frame_done_in same cycle as 2nd box -> frame replays 2 boxes, 2nd marked last.
//  - Random ready toggling over 5 frames vs scoreboard; assert box_out stable while valid&!ready;
//    reset_n pulsed low mid-stream -> all outputs 0, next frame replays from index 0.

Source files
------------

// File: rtl/bbox_frame_collector_if.sv
// Signal bundle between the SVM detector / overlay readout and the bbox frame collector.
// The master side drives detections and stream ready; the slave side is the collector.
interface bbox_frame_collector_if #(
    parameter int COORD_WIDTH = 16,
    parameter int CNT_WIDTH   = 7
);
    logic                       bbox_valid_in;
    logic [COORD_WIDTH-1:0]     bbox_x_start_in;
    logic [COORD_WIDTH-1:0]     bbox_y_start_in;
    logic [COORD_WIDTH-1:0]     bbox_x_end_in;
    logic [COORD_WIDTH-1:0]     bbox_y_end_in;
    logic                       frame_done_in;
    logic                       box_valid_out;
    logic                       box_ready_in;
    logic [4*COORD_WIDTH-1:0]   box_out;
    logic                       box_last_out;
    logic [CNT_WIDTH-1:0]       frame_count_out;
    logic                       frame_overflow_out;
    logic                       frame_empty_out;
    logic                       frame_dropped_out;

    modport master (
        output bbox_valid_in, bbox_x_start_in, bbox_y_start_in, bbox_x_end_in, bbox_y_end_in,
        output frame_done_in, box_ready_in,
        input  box_valid_out, box_out, box_last_out, frame_count_out,
        input  frame_overflow_out, frame_empty_out, frame_dropped_out
    );

    modport slave (
        input  bbox_valid_in, bbox_x_start_in, bbox_y_start_in, bbox_x_end_in, bbox_y_end_in,
        input  frame_done_in, box_ready_in,
        output box_valid_out, box_out, box_last_out, frame_count_out,
        output frame_overflow_out, frame_empty_out, frame_dropped_out
    );
endinterface

// File: rtl/bbox_frame_collector.sv
// Collects per-frame bbox detections into a ping-pong store and, at frame end,
// replays the closed frame as a valid/ready stream while the next frame fills the other bank.
module bbox_frame_collector #(
    parameter int MAX_BOXES   = 64,
    parameter int COORD_WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    bbox_frame_collector_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_BOXES + 1);
    localparam int IDX_W = $clog2(MAX_BOXES);
    localparam int BOX_W = 4 * COORD_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_PRESENT = 2'd2
    } rd_state_e;

    logic [BOX_W-1:0]  mem_r [2*MAX_BOXES];
    logic [CNT_W-1:0]  wr_count_r;
    logic              wr_overflow_r;
    logic              wr_bank_r;
    logic              rd_bank_r;
    logic              swap_pend_r;
    logic [CNT_W-1:0]  frame_count_r;
    logic              frame_overflow_r;
    logic              frame_dropped_r;
    logic              frame_empty_r;
    rd_state_e         rd_state_r;
    rd_state_e         rd_state_s;
    logic [CNT_W-1:0]  rd_idx_r;
    logic [CNT_W-1:0]  rd_idx_s;
    logic              box_valid_r;
    logic [BOX_W-1:0]  box_r;
    logic              box_last_r;
    logic              load_s;
    logic              valid_s;
    logic              empty_s;
    logic              busy_s;
    logic              wr_accept_s;
    logic              wr_reject_s;
    logic              swap_s;
    logic              drop_s;

    // A swap still waiting for the read FSM counts as busy so a second frame end cannot double-swap.
    assign busy_s      = (rd_state_r != ST_IDLE) || swap_pend_r;
    assign wr_accept_s = bus.bbox_valid_in && (wr_count_r < CNT_W'(MAX_BOXES));
    assign wr_reject_s = bus.bbox_valid_in && !wr_accept_s;
    assign swap_s      = bus.frame_done_in && !busy_s;
    assign drop_s      = bus.frame_done_in && busy_s;

    // Box storage: both banks in one array addressed by {bank, index}; contents are never reset
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            mem_r[{wr_bank_r, wr_count_r[IDX_W-1:0]}] <= {bus.bbox_x_start_in, bus.bbox_y_start_in,
                                                          bus.bbox_x_end_in,   bus.bbox_y_end_in};
        end
    end

    // Write-side fill count, overflow tracking, bank swap and per-frame summary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_count_r       <= {CNT_W{1'b0}};
            wr_overflow_r    <= 1'b0;
            wr_bank_r        <= 1'b0;
            rd_bank_r        <= 1'b0;
            swap_pend_r      <= 1'b0;
            frame_count_r    <= {CNT_W{1'b0}};
            frame_overflow_r <= 1'b0;
            frame_dropped_r  <= 1'b0;
        end else begin
            swap_pend_r     <= swap_s;
            frame_dropped_r <= drop_s;
            if (bus.frame_done_in) begin
                wr_count_r    <= {CNT_W{1'b0}};
                wr_overflow_r <= 1'b0;
            end else begin
                if (wr_accept_s) begin
                    wr_count_r <= wr_count_r + CNT_W'(1);
                end
                if (wr_reject_s) begin
                    wr_overflow_r <= 1'b1;
                end
            end
            if (swap_s) begin
                wr_bank_r        <= ~wr_bank_r;
                rd_bank_r        <= wr_bank_r;
                frame_count_r    <= wr_count_r + CNT_W'(wr_accept_s);
                frame_overflow_r <= wr_overflow_r | wr_reject_s;
            end
        end
    end

    // Read FSM state and replay index
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_state_r <= ST_IDLE;
            rd_idx_r   <= {CNT_W{1'b0}};
        end else begin
            rd_state_r <= rd_state_s;
            rd_idx_r   <= rd_idx_s;
        end
    end

    // Read FSM next state and output strobes
    always_comb begin
        rd_state_s = rd_state_r;
        rd_idx_s   = rd_idx_r;
        load_s     = 1'b0;
        valid_s    = box_valid_r;
        empty_s    = 1'b0;
        case (rd_state_r)
            ST_IDLE: begin
                valid_s = 1'b0;
                if (swap_pend_r) begin
                    if (frame_count_r == {CNT_W{1'b0}}) begin
                        empty_s = 1'b1;
                    end else begin
                        rd_state_s = ST_FETCH;
                        rd_idx_s   = {CNT_W{1'b0}};
                    end
                end else begin
                    rd_state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                load_s     = 1'b1;
                valid_s    = 1'b1;
                rd_state_s = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (bus.box_ready_in) begin
                    valid_s = 1'b0;
                    if (box_last_r) begin
                        rd_state_s = ST_IDLE;
                    end else begin
                        rd_state_s = ST_FETCH;
                        rd_idx_s   = rd_idx_r + CNT_W'(1);
                    end
                end else begin
                    valid_s = 1'b1;
                end
            end
            default: begin
                rd_state_s = ST_IDLE;
                valid_s    = 1'b0;
            end
        endcase
    end

    // Registered stream outputs; the box register doubles as the storage read register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            box_valid_r   <= 1'b0;
            box_r         <= {BOX_W{1'b0}};
            box_last_r    <= 1'b0;
            frame_empty_r <= 1'b0;
        end else begin
            box_valid_r   <= valid_s;
            frame_empty_r <= empty_s;
            if (load_s) begin
                box_r      <= mem_r[{rd_bank_r, rd_idx_r[IDX_W-1:0]}];
                box_last_r <= (rd_idx_r == (frame_count_r - CNT_W'(1)));
            end
        end
    end

    assign bus.box_valid_out      = box_valid_r;
    assign bus.box_out            = box_r;
    assign bus.box_last_out       = box_last_r;
    assign bus.frame_count_out    = frame_count_r;
    assign bus.frame_overflow_out = frame_overflow_r;
    assign bus.frame_empty_out    = frame_empty_r;
    assign bus.frame_dropped_out  = frame_dropped_r;
endmodule
